// File: rtl/hydra_pkg.sv
// Shared page-pool types: default page address width, address typedef and pool phase.
package hydra_pkg;

  localparam int unsigned PAGE_ADDR_W = 11;

  typedef logic [PAGE_ADDR_W-1:0] page_addr_t;

  typedef enum logic {
    INIT    = 1'b0,
    RECYCLE = 1'b1
  } pool_state_e;

endpackage

// File: rtl/page_pool_alloc_if.sv
// Allocation/free handshake and pool status between a client (master) and the allocator (slave).
interface page_pool_alloc_if #(
  parameter int unsigned ADDR_W = hydra_pkg::PAGE_ADDR_W
) ();

  logic              alloc_req;
  logic              alloc_vld;
  logic [ADDR_W-1:0] alloc_addr;
  logic              free_vld;
  logic [ADDR_W-1:0] free_addr;
  logic [ADDR_W:0]   free_cnt;
  logic              empty;
  logic              low_wm;
  logic              err_overflow;
  logic              err_underflow;

  modport master (
    output alloc_req, free_vld, free_addr,
    input  alloc_vld, alloc_addr, free_cnt, empty, low_wm, err_overflow, err_underflow
  );

  modport slave (
    input  alloc_req, free_vld, free_addr,
    output alloc_vld, alloc_addr, free_cnt, empty, low_wm, err_overflow, err_underflow
  );

endinterface

// File: rtl/page_ring_sdp.sv
// Simple dual-port ring storage for recycled page addresses; 1-cycle registered read.
module page_ring_sdp #(
  parameter int unsigned ADDR_W = hydra_pkg::PAGE_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data holds between reads so a granted address stays stable.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/page_pool_alloc.sv
// Free-page allocator: sequential issue after reset, then recycled pages from a ring,
// with same-cycle free->alloc bypass, occupancy count, low watermark and sticky errors.
module page_pool_alloc
  import hydra_pkg::*;
#(
  parameter int unsigned ADDR_W = PAGE_ADDR_W,
  parameter int unsigned LOW_WM = 16
) (
  input  logic             clk,
  input  logic             rst,
  page_pool_alloc_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  pool_state_e       state_q, state_d;
  logic [CNT_W-1:0]  init_next_q, init_next_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  ring_cnt_q, ring_cnt_d;
  logic [CNT_W-1:0]  free_cnt_q, free_cnt_d;
  logic              alloc_vld_q, alloc_vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sel_ring_q, sel_ring_d;
  logic              empty_q, empty_d;
  logic              low_wm_q, low_wm_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_udf_q, err_udf_d;

  logic              full;
  logic              bypass;
  logic              init_grant;
  logic              ring_grant;
  logic              free_acc;
  logic [ADDR_W-1:0] ring_rdata;

  page_ring_sdp #(.ADDR_W(ADDR_W)) u_ring (
    .clk   (clk),
    .we    (free_acc),
    .waddr (tail_q),
    .wdata (bus.free_addr),
    .re    (ring_grant),
    .raddr (head_q),
    .rdata (ring_rdata)
  );

  // All decisions use pre-cycle state; bypass consumes the free without touching the ring.
  always_comb begin
    state_d     = state_q;
    init_next_d = init_next_q;
    head_d      = head_q;
    tail_d      = tail_q;
    ring_cnt_d  = ring_cnt_q;
    free_cnt_d  = free_cnt_q;
    alloc_vld_d = 1'b0;
    addr_d      = addr_q;
    sel_ring_d  = sel_ring_q;
    err_ovf_d   = err_ovf_q;
    err_udf_d   = err_udf_q;

    full       = (free_cnt_q == CNT_W'(DEPTH));
    bypass     = (state_q == RECYCLE) && (ring_cnt_q == '0) && bus.alloc_req && bus.free_vld;
    init_grant = (state_q == INIT) && bus.alloc_req;
    ring_grant = (state_q == RECYCLE) && bus.alloc_req && (ring_cnt_q != '0);
    free_acc   = bus.free_vld && !full && !bypass;

    if (init_grant) begin
      alloc_vld_d = 1'b1;
      addr_d      = init_next_q[ADDR_W-1:0];
      sel_ring_d  = 1'b0;
      init_next_d = init_next_q + CNT_W'(1);
      if (init_next_q == CNT_W'(DEPTH - 1)) state_d = RECYCLE;
    end else if (ring_grant) begin
      alloc_vld_d = 1'b1;
      sel_ring_d  = 1'b1;
      head_d      = head_q + ADDR_W'(1);
    end else if (bypass) begin
      alloc_vld_d = 1'b1;
      addr_d      = bus.free_addr;
      sel_ring_d  = 1'b0;
    end else if (bus.alloc_req) begin
      err_udf_d = 1'b1;
    end

    if (free_acc) tail_d = tail_q + ADDR_W'(1);
    if (bus.free_vld && full) err_ovf_d = 1'b1;

    ring_cnt_d = ring_cnt_q + CNT_W'(free_acc) - CNT_W'(ring_grant);
    free_cnt_d = free_cnt_q + CNT_W'(free_acc) - CNT_W'(init_grant || ring_grant);
    empty_d    = (free_cnt_d == '0);
    low_wm_d   = (free_cnt_d <= CNT_W'(LOW_WM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_next_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      ring_cnt_q  <= '0;
      free_cnt_q  <= CNT_W'(DEPTH);
      alloc_vld_q <= 1'b0;
      addr_q      <= '0;
      sel_ring_q  <= 1'b0;
      empty_q     <= 1'b0;
      low_wm_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_udf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_next_q <= init_next_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      ring_cnt_q  <= ring_cnt_d;
      free_cnt_q  <= free_cnt_d;
      alloc_vld_q <= alloc_vld_d;
      addr_q      <= addr_d;
      sel_ring_q  <= sel_ring_d;
      empty_q     <= empty_d;
      low_wm_q    <= low_wm_d;
      err_ovf_q   <= err_ovf_d;
      err_udf_q   <= err_udf_d;
    end
  end

  // Granted address comes from the ring read register or the local address register.
  assign bus.alloc_addr    = sel_ring_q ? ring_rdata : addr_q;
  assign bus.alloc_vld     = alloc_vld_q;
  assign bus.free_cnt      = free_cnt_q;
  assign bus.empty         = empty_q;
  assign bus.low_wm        = low_wm_q;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.err_underflow = err_udf_q;

endmodule

// File: tb/tb_page_pool_alloc.sv
// Directed-vector bench for page_pool_alloc with an 8-page pool and low watermark of 2.
module tb_page_pool_alloc;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned LOW_WM = 2;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  page_pool_alloc_if #(.ADDR_W(ADDR_W)) bus ();

  page_pool_alloc #(.ADDR_W(ADDR_W), .LOW_WM(LOW_WM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic req, input logic fv, input logic [ADDR_W-1:0] fa);
    bus.alloc_req = req;
    bus.free_vld  = fv;
    bus.free_addr = fa;
    @(posedge clk);
    #1;
    bus.alloc_req = 1'b0;
    bus.free_vld  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic grant(input string tag, input int addr, input int cnt);
    cyc(1'b1, 1'b0, '0);
    chk({tag, "_vld"}, 32'(bus.alloc_vld), 1);
    chk({tag, "_addr"}, 32'(bus.alloc_addr), 32'(addr));
    chk({tag, "_cnt"}, 32'(bus.free_cnt), 32'(cnt));
  endtask

  task automatic free(input string tag, input int addr, input int cnt);
    cyc(1'b0, 1'b1, ADDR_W'(addr));
    chk({tag, "_vld"}, 32'(bus.alloc_vld), 0);
    chk({tag, "_cnt"}, 32'(bus.free_cnt), 32'(cnt));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    bus.alloc_req = 1'b0;
    bus.free_vld  = 1'b0;
    bus.free_addr = '0;

    // Reset state
    do_reset();
    chk("rst_vld", 32'(bus.alloc_vld), 0);
    chk("rst_addr", 32'(bus.alloc_addr), 0);
    chk("rst_cnt", 32'(bus.free_cnt), 8);
    chk("rst_empty", 32'(bus.empty), 0);
    chk("rst_lowwm", 32'(bus.low_wm), 0);
    chk("rst_ovf", 32'(bus.err_overflow), 0);
    chk("rst_udf", 32'(bus.err_underflow), 0);

    // Sequential INIT grants 0..7
    for (int i = 0; i < 8; i++) begin
      grant("init", i, 7 - i);
      chk("init_lowwm", 32'(bus.low_wm), ((7 - i) <= 2) ? 1 : 0);
      chk("init_empty", 32'(bus.empty), (i == 7) ? 1 : 0);
    end
    cyc(1'b0, 1'b0, '0);
    chk("idle_vld", 32'(bus.alloc_vld), 0);

    // Recycle in free order
    free("fr5", 5, 1);
    free("fr2", 2, 2);
    free("fr7", 7, 3);
    chk("fr_lowwm", 32'(bus.low_wm), 0);
    chk("fr_empty", 32'(bus.empty), 0);
    grant("rc5", 5, 2);
    grant("rc2", 2, 1);
    grant("rc7", 7, 0);
    chk("rc_empty", 32'(bus.empty), 1);

    // Bypass with empty ring
    cyc(1'b1, 1'b1, 3'd4);
    chk("byp_vld", 32'(bus.alloc_vld), 1);
    chk("byp_addr", 32'(bus.alloc_addr), 4);
    chk("byp_cnt", 32'(bus.free_cnt), 0);
    chk("byp_ovf", 32'(bus.err_overflow), 0);
    chk("byp_udf", 32'(bus.err_underflow), 0);

    // Underflow
    cyc(1'b1, 1'b0, '0);
    chk("udf_vld", 32'(bus.alloc_vld), 0);
    chk("udf_flag", 32'(bus.err_underflow), 1);
    chk("udf_cnt", 32'(bus.free_cnt), 0);
    cyc(1'b0, 1'b0, '0);
    chk("udf_sticky", 32'(bus.err_underflow), 1);

    // Free during INIT is served only after the sequential pages
    do_reset();
    grant("i0", 0, 7);
    grant("i1", 1, 6);
    grant("i2", 2, 5);
    free("ifr1", 1, 6);
    grant("i3", 3, 5);
    grant("i4", 4, 4);
    grant("i5", 5, 3);
    grant("i6", 6, 2);
    grant("i7", 7, 1);
    grant("ir1", 1, 0);

    // Simultaneous pop and push with a non-empty ring
    free("sfr6", 6, 1);
    cyc(1'b1, 1'b1, 3'd3);
    chk("sim_vld", 32'(bus.alloc_vld), 1);
    chk("sim_addr", 32'(bus.alloc_addr), 6);
    chk("sim_cnt", 32'(bus.free_cnt), 1);
    grant("sim3", 3, 0);

    // Overflow when full, alloc in the same cycle still granted
    do_reset();
    cyc(1'b1, 1'b1, 3'd3);
    chk("ovf_vld", 32'(bus.alloc_vld), 1);
    chk("ovf_addr", 32'(bus.alloc_addr), 0);
    chk("ovf_flag", 32'(bus.err_overflow), 1);
    chk("ovf_cnt", 32'(bus.free_cnt), 7);

    // Reset with a grant pending drops it and clears sticky flags
    grant("pre1", 1, 6);
    rst = 1'b1;
    cyc(1'b1, 1'b0, '0);
    rst = 1'b0;
    chk("mrst_vld", 32'(bus.alloc_vld), 0);
    chk("mrst_cnt", 32'(bus.free_cnt), 8);
    chk("mrst_ovf", 32'(bus.err_overflow), 0);
    chk("mrst_udf", 32'(bus.err_underflow), 0);
    grant("post0", 0, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
